operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//   Initiator side of the register file. Accepts decoded instructions and drives the register file read addresses.
//   Captures the registered read data, one cycle later, and presents the operands downstream with a valid/ready handshake.
//   Owns the write port: drives we/wr/wd from writeback and never writes x0.
//   A busy-bit scoreboard stalls RAW and WAW hazards against writes still in flight.
// PARAMETERS
//   XLEN   32  operand/data width
//   AW     5   register address width
//   NREG   32  number of architectural registers (2**AW)
// PORTS
//   clk       in   1     clock, rising edge
//   rst       in   1     asynchronous reset, active low
//   id_valid  in   1     decoded instruction valid
//   id_ready  out  1     instruction accepted when id_valid & id_ready
//   id_rs1    in   AW    source register 1
//   id_rs2    in   AW    source register 2
//   id_rd     in   AW    destination register
//   id_rd_en  in   1     instruction writes id_rd
//   op_valid  out  1     operands valid
//   op_ready  in   1     downstream accepts operands
//   op_a      out  XLEN  value of rs1
//   op_b      out  XLEN  value of rs2
//   op_rd     out  AW    destination passed through
//   op_rd_en  out  1     destination enable passed through
//   wb_valid  in   1     writeback request
//   wb_rd     in   AW    writeback register
//   wb_data   in   XLEN  writeback data
//   rf_rr1    out  AW    register file read address 1
//   rf_rr2    out  AW    register file read address 2
//   rf_rd1    in   XLEN  register file read data 1; registered, valid the cycle after the address
//   rf_rd2    in   XLEN  register file read data 2
//   rf_we     out  1     register file write enable
//   rf_wr     out  AW    register file write address
//   rf_wd     out  XLEN  register file write data
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, busy=0; op_valid, op_a, op_b, op_rd, op_rd_en all 0.
//   A reset mid-operation drops any held instruction. The register file is cleared by the same reset.
// - Write path (combinational): rf_we = wb_valid & (wb_rd!=0); rf_wr=wb_rd; rf_wd=wb_data.
// - Scoreboard busy[NREG]; busy[0] is always 0.
//   Set busy[id_rd] on accept when id_rd_en and id_rd!=0. Clear busy[wb_rd] on wb_valid.
//   If the same register is set and cleared in one cycle, set wins.
// - hazard = busy[id_rs1] | busy[id_rs2] | (id_rd_en & busy[id_rd]).
// - FSM:
//   IDLE: id_ready = ~hazard. rf_rr1/rf_rr2 = id_rs1/id_rs2. On accept, latch rs/rd fields and go to READ.
//   READ: rf_rr = latched rs. Latch op_a/op_b from rf_rd1/rf_rd2 and set op_valid; go to VALID.
//     An operand is forced to 0 if its rs==0.
//   VALID: op_valid=1, operands held stable. On op_ready: op_valid=0, go to IDLE.
//   id_ready=0 outside IDLE.
// - Latency and throughput:
//   Accept at edge N; op_valid is high after edge N+1.
//   Minimum of 3 cycles per instruction when op_ready is held high.
// - Spurious writeback to a non-busy register: the write is performed and busy is unchanged.
// CONFIGURATION
// - REGFILE_BYPASS_EN defined:
//   - A source whose busy bit is being cleared this cycle (wb_valid & wb_rd==rs) does not stall.
//   - The block accepts, registers wb_data at the accept edge, and substitutes it for rf_rdX in READ.
//     This is needed because the register file returns the pre-write value.
// - REGFILE_BYPASS_EN undefined:
//   - That source stalls one extra cycle.
//   - The read is then issued after the write has landed.
//   - No forwarding datapath.
// TESTING
// 1. Reset, then write x5=0x1234_5678 via wb, issue rs1=5, rs2=0 -> op_a=0x12345678, op_b=0 two edges after accept.
// 2. wb_valid, wb_rd=0, wb_data=0xFFFF_FFFF -> rf_we=0; a later read of x0 yields op_a=0.
// 3. Issue rd=7 (busy), then rs1=7 -> id_ready=0 until wb x7=0xA5; without bypass, op_a=0xA5 after the stall.
// 4. REGFILE_BYPASS_EN: rs1=7 while busy, wb x7=0xBEEF in the same cycle -> accept with no stall, op_a=0xBEEF.
// 5. Hold op_ready=0 for 4 cycles in VALID -> op_a/op_b/op_valid stable, id_ready=0; release -> IDLE next edge.
// 6. Assert rst low during READ -> op_valid=0 and busy=0 immediately; first instruction after reset accepted normally.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: issues register file reads, tracks in-flight writes with a busy-bit
// scoreboard, owns the write port. Optional forwarding of same-cycle writeback: REGFILE_BYPASS_EN.
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_rd_en,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [AW-1:0]   op_rd,
    output logic            op_rd_en,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [AW-1:0]   rf_rr1,
    output logic [AW-1:0]   rf_rr2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wr,
    output logic [XLEN-1:0] rf_wd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [NREG-1:0] busy, busy_nxt;
    logic            hazard;
    logic            accept;
    logic            rs1_stall, rs2_stall;
    logic            hit1, hit2;
    logic [XLEN-1:0] fwd_wd;

    logic [AW-1:0]   rs1_p0, rs2_p0, rd_p0;
    logic            rd_en_p0;

    logic            vld_p1;
    logic [XLEN-1:0] op_a_p1, op_b_p1;
    logic [AW-1:0]   op_rd_p1;
    logic            op_rd_en_p1;

    // x0 always reads as zero; otherwise a forwarded write beats the stale register file value.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [AW-1:0]   rs,
        input logic            hit,
        input logic [XLEN-1:0] fwd,
        input logic [XLEN-1:0] rf
    );
        if (rs == '0) return '0;
        if (hit)      return fwd;
        return rf;
    endfunction

    assign rf_we = wb_valid && (wb_rd != '0);
    assign rf_wr = wb_rd;
    assign rf_wd = wb_data;

`ifdef REGFILE_BYPASS_EN
    logic wb_hit1, wb_hit2;
    logic byp1_p0, byp2_p0;
    logic [XLEN-1:0] byp_wd_p0;

    assign wb_hit1   = wb_valid && (wb_rd == id_rs1);
    assign wb_hit2   = wb_valid && (wb_rd == id_rs2);
    assign rs1_stall = busy[id_rs1] && !wb_hit1;
    assign rs2_stall = busy[id_rs2] && !wb_hit2;

    // Register file returns the pre-write value, so capture the write data at the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            byp1_p0   <= wb_hit1;
            byp2_p0   <= wb_hit2;
            byp_wd_p0 <= wb_data;
        end
    end

    assign hit1   = byp1_p0;
    assign hit2   = byp2_p0;
    assign fwd_wd = byp_wd_p0;
`else
    assign rs1_stall = busy[id_rs1];
    assign rs2_stall = busy[id_rs2];
    assign hit1      = 1'b0;
    assign hit2      = 1'b0;
    assign fwd_wd    = '0;
`endif

    assign hazard = rs1_stall || rs2_stall || (id_rd_en && busy[id_rd]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        id_ready  = 1'b0;
        accept    = 1'b0;
        rf_rr1    = rs1_p0;
        rf_rr2    = rs2_p0;
        case (state)
            IDLE: begin
                id_ready = !hazard;
                accept   = id_valid && !hazard;
                rf_rr1   = id_rs1;
                rf_rr2   = id_rs2;
                if (accept) state_nxt = READ;
            end
            READ: begin
                state_nxt = VALID;
            end
            VALID: begin
                if (op_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Set after clear so a register reissued in the same cycle its write retires stays busy.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid) busy_nxt[wb_rd] = 1'b0;
        if (accept && id_rd_en && (id_rd != '0)) busy_nxt[id_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // p0: instruction fields captured at accept; read addresses replayed from here in READ.
    always_ff @(posedge clk) begin
        if (accept) begin
            rs1_p0   <= id_rs1;
            rs2_p0   <= id_rs2;
            rd_p0    <= id_rd;
            rd_en_p0 <= id_rd_en;
        end
    end

    // p1: operands captured from registered read data, held until downstream takes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1      <= 1'b0;
            op_a_p1     <= '0;
            op_b_p1     <= '0;
            op_rd_p1    <= '0;
            op_rd_en_p1 <= 1'b0;
        end else if (state == READ) begin
            vld_p1      <= 1'b1;
            op_a_p1     <= pick_operand(rs1_p0, hit1, fwd_wd, rf_rd1);
            op_b_p1     <= pick_operand(rs2_p0, hit2, fwd_wd, rf_rd2);
            op_rd_p1    <= rd_p0;
            op_rd_en_p1 <= rd_en_p0;
        end else if ((state == VALID) && op_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign op_valid = vld_p1;
    assign op_a     = op_a_p1;
    assign op_b     = op_b_p1;
    assign op_rd    = op_rd_p1;
    assign op_rd_en = op_rd_en_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file and an expected-operand queue.
module tb_operand_fetch;

`ifdef REGFILE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_rd_en = 1'b0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] op_a, op_b;
    logic [4:0]  op_rd;
    logic        op_rd_en;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  rf_rr1, rf_rr2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rd_en;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   waited;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_en(id_rd_en),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_rd_en(op_rd_en),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_rr1(rf_rr1), .rf_rr2(rf_rr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd)
    );

    // Register file: registered read returning the pre-write value, cleared by reset.
    logic [31:0] regs [32];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            rf_rd1 <= '0;
            rf_rd2 <= '0;
        end else begin
            if (rf_we) regs[rf_wr] <= rf_wd;
            rf_rd1 <= regs[rf_rr1];
            rf_rd2 <= regs[rf_rr2];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
        #1;
        chk("rf_we", rf_we, (rd != 5'd0));
        chk("rf_wr", rf_wr, rd);
        chk("rf_wd", rf_wd, d);
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rd_en, input logic [31:0] ea, input logic [31:0] eb,
                         output int n_wait);
        exp_t e;
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_en = rd_en;
        n_wait = 0;
        #1;
        while (!id_ready && n_wait < 20) begin
            @(negedge clk); #1;
            n_wait++;
        end
        chk("accept", id_ready, 1'b1);
        e.a = ea; e.b = eb; e.rd = rd; e.rd_en = rd_en;
        sb.push_back(e);
        @(negedge clk);
        id_valid = 1'b0;
        chk("read_not_valid", op_valid, 1'b0);
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!op_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("op_latency", n, 0);
        chk("sb_has_entry", (sb.size() != 0), 1'b1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk("op_a", op_a, e.a);
        chk("op_b", op_b, e.b);
        chk("op_rd", op_rd, e.rd);
        chk("op_rd_en", op_rd_en, e.rd_en);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", op_valid, 1'b1);
            chk("hold_a", op_a, e.a);
            chk("hold_b", op_b, e.b);
            chk("hold_id_ready", id_ready, 1'b0);
        end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk("op_valid_drop", op_valid, 1'b0);
    endtask

    // Source rs1=7 is busy; writeback of x7 arrives while the instruction waits.
    task automatic raw_case(input logic [31:0] d, input int pre);
        exp_t e;
        logic pushed;
        id_valid = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd0; id_rd = 5'd0; id_rd_en = 1'b0;
        repeat (pre) begin
            #1;
            chk("raw_stall", id_ready, 1'b0);
            @(negedge clk);
        end
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = d;
        #1;
        chk("raw_wb_cycle_ready", id_ready, BYP);
        e.a = d; e.b = '0; e.rd = '0; e.rd_en = 1'b0;
        pushed = id_ready;
        if (pushed) sb.push_back(e);
        @(negedge clk);
        wb_valid = 1'b0;
        if (!pushed) begin
            #1;
            chk("raw_after_wb_ready", id_ready, 1'b1);
            sb.push_back(e);
            @(negedge clk);
        end
        id_valid = 1'b0;
        chk("raw_read_not_valid", op_valid, 1'b0);
        collect(0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_op_a", op_a, 32'h0);
        chk("rst_op_b", op_b, 32'h0);
        chk("rst_op_rd", op_rd, 5'd0);
        chk("rst_op_rd_en", op_rd_en, 1'b0);
        chk("rst_id_ready", id_ready, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        wb(5'd5, 32'h1234_5678);
        issue(5'd5, 5'd0, 5'd0, 1'b0, 32'h1234_5678, 32'h0, waited);
        collect(0);

        wb(5'd0, 32'hFFFF_FFFF);
        issue(5'd0, 5'd5, 5'd3, 1'b1, 32'h0, 32'h1234_5678, waited);
        collect(0);
        wb(5'd3, 32'h0000_0033);

        wb(5'd12, 32'h00C0_FFEE);
        issue(5'd12, 5'd3, 5'd0, 1'b0, 32'h00C0_FFEE, 32'h0000_0033, waited);
        chk("spurious_no_stall", waited, 0);
        collect(0);

        issue(5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0, waited);
        collect(0);
        raw_case(32'h0000_00A5, 3);

        issue(5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0, waited);
        collect(0);
        raw_case(32'h0000_BEEF, 0);

        issue(5'd5, 5'd7, 5'd0, 1'b0, 32'h1234_5678, 32'h0000_BEEF, waited);
        collect(4);
        #1;
        chk("idle_after_release", id_ready, 1'b1);

        issue(5'd5, 5'd0, 5'd9, 1'b1, 32'h1234_5678, 32'h0, waited);
        rst = 1'b0;
        #1;
        chk("midrst_op_valid", op_valid, 1'b0);
        chk("midrst_op_rd_en", op_rd_en, 1'b0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        issue(5'd9, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0, waited);
        chk("post_rst_no_stall", waited, 0);
        collect(0);

        wb(5'd3, 32'h0000_0055);
        issue(5'd3, 5'd0, 5'd0, 1'b0, 32'h0000_0055, 32'h0, waited);
        collect(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
